// File: rtl/ami_rd_arb.sv
// ami_rd_arb
//   Round-robin arbiter that shares one AMI user read port (AR/R) among NCL read clients.
//   The granted client index is carried in the top CIW bits of usr_arid. R beats are
//   steered back to the owner by decoding those bits. Each client is limited to MAX_OS
//   outstanding bursts.
// Ports
//   usr_clk, usr_reset_n        clock, synchronous active-low reset
//   cl_ar*  (in), cl_arready    per-client read address channels (flattened, client c at slice c)
//   cl_r*   (out), cl_rready    shared R payload, per-client rvalid/rready
//   usr_ar* (out), usr_arready  AR channel toward the AMI port (registered slot)
//   usr_r*  (in),  usr_rready   R channel from the AMI port
//   err_bad_rid, err_os_uf      sticky error flags
module ami_rd_arb #(
  parameter int NCL    = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int MAX_OS = 4,
  localparam int CIW   = $clog2(NCL),
  localparam int CW    = AXI_IW - CIW
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset_n,
  input  logic [NCL*CW-1:0]     cl_arid,
  input  logic [NCL*AXI_AW-1:0] cl_araddr,
  input  logic [NCL*AXI_LW-1:0] cl_arlen,
  input  logic [NCL*AXI_SW-1:0] cl_arsize,
  input  logic [NCL*2-1:0]      cl_arburst,
  input  logic [NCL-1:0]        cl_arvalid,
  output logic [NCL-1:0]        cl_arready,
  output logic [CW-1:0]         cl_rid,
  output logic [AXI_DW-1:0]     cl_rdata,
  output logic [1:0]            cl_rresp,
  output logic                  cl_rlast,
  output logic [NCL-1:0]        cl_rvalid,
  input  logic [NCL-1:0]        cl_rready,
  output logic [AXI_IW-1:0]     usr_arid,
  output logic [AXI_AW-1:0]     usr_araddr,
  output logic [AXI_LW-1:0]     usr_arlen,
  output logic [AXI_SW-1:0]     usr_arsize,
  output logic [1:0]            usr_arburst,
  output logic                  usr_arvalid,
  input  logic                  usr_arready,
  input  logic [AXI_IW-1:0]     usr_rid,
  input  logic [AXI_DW-1:0]     usr_rdata,
  input  logic [1:0]            usr_rresp,
  input  logic                  usr_rlast,
  input  logic                  usr_rvalid,
  output logic                  usr_rready,
  output logic                  err_bad_rid,
  output logic                  err_os_uf
);

  logic             slot_free_s;
  logic [NCL-1:0]   elig_s;
  logic             gnt_vld_s;
  logic [CIW-1:0]   gnt_idx_s;
  logic [CIW-1:0]   rr_ptr_r;
  logic [3:0]       os_cnt_r [NCL];
  logic [NCL-1:0]   os_dec_s;
  logic [CIW-1:0]   r_idx_s;
  logic             r_bad_s;
  logic             r_last_fire_s;
  int               cand_s;

  // The AR slot can take a new request when empty or being accepted this cycle.
  assign slot_free_s = !usr_arvalid || usr_arready;

  // R-side decode: client index lives in the top CIW id bits; indices >= NCL are unroutable.
  assign r_idx_s       = usr_rid[AXI_IW-1 -: CIW];
  assign r_bad_s       = ({1'b0, r_idx_s} >= (CIW+1)'(NCL));
  assign r_last_fire_s = usr_rvalid && usr_rready && usr_rlast;

  // Shared R payload is broadcast; only rvalid/rready are per client.
  assign cl_rid   = usr_rid[CW-1:0];
  assign cl_rdata = usr_rdata;
  assign cl_rresp = usr_rresp;
  assign cl_rlast = usr_rlast;

  // Eligibility: requesting and below the outstanding-burst limit (full clients are skipped).
  always_comb begin
    elig_s = '0;
    for (int c = 0; c < NCL; c++) begin
      elig_s[c] = cl_arvalid[c] && (os_cnt_r[c] < 4'(MAX_OS));
    end
  end

  // Round-robin pick starting one past the last winner; no pick while the slot is stalled.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = 0;
    if (slot_free_s) begin
      for (int i = 1; i <= NCL; i++) begin
        cand_s = (int'(rr_ptr_r) + i) % NCL;
        if (!gnt_vld_s && elig_s[cand_s]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = CIW'(cand_s);
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // One-hot ready toward the winning client.
  always_comb begin
    cl_arready = '0;
    for (int c = 0; c < NCL; c++) begin
      cl_arready[c] = gnt_vld_s && (gnt_idx_s == CIW'(c));
    end
  end

  // R steering; an unroutable id matches no client, so it is accepted and dropped.
  always_comb begin
    cl_rvalid  = '0;
    usr_rready = 1'b1;
    os_dec_s   = '0;
    for (int c = 0; c < NCL; c++) begin
      if (r_idx_s == CIW'(c)) begin
        cl_rvalid[c] = usr_rvalid;
        usr_rready   = cl_rready[c];
        os_dec_s[c]  = r_last_fire_s && !r_bad_s;
      end else begin
        cl_rvalid[c] = 1'b0;
      end
    end
  end

  // AR slot, round-robin pointer, outstanding counters and sticky error flags.
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      usr_arid    <= '0;
      usr_araddr  <= '0;
      usr_arlen   <= '0;
      usr_arsize  <= '0;
      usr_arburst <= '0;
      usr_arvalid <= 1'b0;
      rr_ptr_r    <= CIW'(NCL-1);
      err_bad_rid <= 1'b0;
      err_os_uf   <= 1'b0;
      for (int c = 0; c < NCL; c++) begin
        os_cnt_r[c] <= 4'd0;
      end
    end else begin
      if (slot_free_s) begin
        if (gnt_vld_s) begin
          usr_arid    <= {gnt_idx_s, cl_arid[gnt_idx_s*CW +: CW]};
          usr_araddr  <= cl_araddr[gnt_idx_s*AXI_AW +: AXI_AW];
          usr_arlen   <= cl_arlen[gnt_idx_s*AXI_LW +: AXI_LW];
          usr_arsize  <= cl_arsize[gnt_idx_s*AXI_SW +: AXI_SW];
          usr_arburst <= cl_arburst[gnt_idx_s*2 +: 2];
          usr_arvalid <= 1'b1;
          rr_ptr_r    <= gnt_idx_s;
        end else begin
          usr_arvalid <= 1'b0;
        end
      end
      if (usr_rvalid && r_bad_s) begin
        err_bad_rid <= 1'b1;
      end
      // Grant and last for the same client in one cycle cancel out.
      for (int c = 0; c < NCL; c++) begin
        if (cl_arready[c] && !os_dec_s[c]) begin
          os_cnt_r[c] <= os_cnt_r[c] + 4'd1;
        end else if (os_dec_s[c] && !cl_arready[c]) begin
          if (os_cnt_r[c] == 4'd0) begin
            err_os_uf <= 1'b1;
          end else begin
            os_cnt_r[c] <= os_cnt_r[c] - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ami_rd_arb.sv
// tb_ami_rd_arb
//   Directed bench for ami_rd_arb. Main instance uses NCL=4; a second instance with
//   NCL=3 exercises unroutable read ids.
module tb_ami_rd_arb;

  logic         clk = 1'b0;
  logic         usr_reset_n;
  logic [23:0]  cl_arid;
  logic [127:0] cl_araddr;
  logic [31:0]  cl_arlen;
  logic [11:0]  cl_arsize;
  logic [7:0]   cl_arburst;
  logic [3:0]   cl_arvalid;
  logic [3:0]   cl_arready;
  logic [5:0]   cl_rid;
  logic [127:0] cl_rdata;
  logic [1:0]   cl_rresp;
  logic         cl_rlast;
  logic [3:0]   cl_rvalid;
  logic [3:0]   cl_rready;
  logic [7:0]   usr_arid;
  logic [31:0]  usr_araddr;
  logic [7:0]   usr_arlen;
  logic [2:0]   usr_arsize;
  logic [1:0]   usr_arburst;
  logic         usr_arvalid;
  logic         usr_arready;
  logic [7:0]   usr_rid;
  logic [127:0] usr_rdata;
  logic [1:0]   usr_rresp;
  logic         usr_rlast;
  logic         usr_rvalid;
  logic         usr_rready;
  logic         err_bad_rid;
  logic         err_os_uf;

  logic [17:0]  d3_cl_arid;
  logic [95:0]  d3_cl_araddr;
  logic [23:0]  d3_cl_arlen;
  logic [8:0]   d3_cl_arsize;
  logic [5:0]   d3_cl_arburst;
  logic [2:0]   d3_cl_arvalid;
  logic [2:0]   d3_cl_arready;
  logic [5:0]   d3_cl_rid;
  logic [127:0] d3_cl_rdata;
  logic [1:0]   d3_cl_rresp;
  logic         d3_cl_rlast;
  logic [2:0]   d3_cl_rvalid;
  logic [2:0]   d3_cl_rready;
  logic [7:0]   d3_usr_arid;
  logic [31:0]  d3_usr_araddr;
  logic [7:0]   d3_usr_arlen;
  logic [2:0]   d3_usr_arsize;
  logic [1:0]   d3_usr_arburst;
  logic         d3_usr_arvalid;
  logic         d3_usr_rready;
  logic         d3_err_bad_rid;
  logic         d3_err_os_uf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ami_rd_arb dut (
    .usr_clk(clk), .usr_reset_n(usr_reset_n),
    .cl_arid(cl_arid), .cl_araddr(cl_araddr), .cl_arlen(cl_arlen), .cl_arsize(cl_arsize),
    .cl_arburst(cl_arburst), .cl_arvalid(cl_arvalid), .cl_arready(cl_arready),
    .cl_rid(cl_rid), .cl_rdata(cl_rdata), .cl_rresp(cl_rresp), .cl_rlast(cl_rlast),
    .cl_rvalid(cl_rvalid), .cl_rready(cl_rready),
    .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen), .usr_arsize(usr_arsize),
    .usr_arburst(usr_arburst), .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
    .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp), .usr_rlast(usr_rlast),
    .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .err_bad_rid(err_bad_rid), .err_os_uf(err_os_uf)
  );

  ami_rd_arb #(.NCL(3)) dut3 (
    .usr_clk(clk), .usr_reset_n(usr_reset_n),
    .cl_arid(d3_cl_arid), .cl_araddr(d3_cl_araddr), .cl_arlen(d3_cl_arlen), .cl_arsize(d3_cl_arsize),
    .cl_arburst(d3_cl_arburst), .cl_arvalid(d3_cl_arvalid), .cl_arready(d3_cl_arready),
    .cl_rid(d3_cl_rid), .cl_rdata(d3_cl_rdata), .cl_rresp(d3_cl_rresp), .cl_rlast(d3_cl_rlast),
    .cl_rvalid(d3_cl_rvalid), .cl_rready(d3_cl_rready),
    .usr_arid(d3_usr_arid), .usr_araddr(d3_usr_araddr), .usr_arlen(d3_usr_arlen),
    .usr_arsize(d3_usr_arsize), .usr_arburst(d3_usr_arburst), .usr_arvalid(d3_usr_arvalid),
    .usr_arready(usr_arready),
    .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp), .usr_rlast(usr_rlast),
    .usr_rvalid(usr_rvalid), .usr_rready(d3_usr_rready),
    .err_bad_rid(d3_err_bad_rid), .err_os_uf(d3_err_os_uf)
  );

  task automatic do_reset();
    usr_reset_n = 1'b0;
    cl_arvalid = 4'b0000; cl_rready = 4'b0000; usr_arready = 1'b1;
    usr_rid = 8'h00; usr_rdata = '0; usr_rresp = 2'b00; usr_rlast = 1'b0; usr_rvalid = 1'b0;
    d3_cl_rready = 3'b000;
    repeat (2) @(posedge clk);
    #1 usr_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (usr_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b exp 0", usr_arvalid); end
    n_checks++; if (usr_arid !== 8'h00) begin n_fail++; $display("FAIL reset_arid: got %h exp 00", usr_arid); end
    n_checks++; if (usr_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h exp 0", usr_araddr); end
    n_checks++; if (cl_arready !== 4'b0000) begin n_fail++; $display("FAIL reset_arready: got %b exp 0000", cl_arready); end
    n_checks++; if ({err_bad_rid, err_os_uf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b exp 00", {err_bad_rid, err_os_uf}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_id;
    do_reset();
    cl_arvalid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (cl_arready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_arready k=%0d: got %b exp %b", k, cl_arready, 4'(1 << (k % 4))); end
      @(posedge clk); #1;
      exp_id = {2'(k % 4), 6'(16 + k % 4)};
      n_checks++; if (usr_arvalid !== 1'b1 || usr_arid !== exp_id) begin n_fail++; $display("FAIL rr_arid k=%0d: got %b/%h exp 1/%h", k, usr_arvalid, usr_arid, exp_id); end
      n_checks++; if (usr_araddr !== 32'((k % 4 + 1) * 32'h1000) || usr_arlen !== 8'(k % 4)) begin n_fail++; $display("FAIL rr_payload k=%0d: got %h/%h", k, usr_araddr, usr_arlen); end
    end
    cl_arvalid = 4'b0000;
  endtask

  task automatic test_stall();
    do_reset();
    cl_arvalid = 4'b1111;
    repeat (3) @(posedge clk);
    #1 usr_arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (cl_arready !== 4'b0000) begin n_fail++; $display("FAIL stall_arready i=%0d: got %b exp 0000", i, cl_arready); end
      n_checks++; if (usr_arvalid !== 1'b1 || usr_arid !== 8'h92 || usr_araddr !== 32'h3000) begin n_fail++; $display("FAIL stall_hold i=%0d: got %b/%h/%h exp 1/92/3000", i, usr_arvalid, usr_arid, usr_araddr); end
      @(posedge clk); #1;
    end
    usr_arready = 1'b1;
    #1;
    n_checks++; if (cl_arready !== 4'b1000) begin n_fail++; $display("FAIL stall_release_arready: got %b exp 1000", cl_arready); end
    @(posedge clk); #1;
    n_checks++; if (usr_arid !== 8'hD3 || usr_araddr !== 32'h4000) begin n_fail++; $display("FAIL stall_next: got %h/%h exp d3/4000", usr_arid, usr_araddr); end
    cl_arvalid = 4'b0000;
  endtask

  task automatic test_max_os();
    do_reset();
    cl_arvalid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (cl_arready !== 4'b0010) begin n_fail++; $display("FAIL os_fill i=%0d: got %b exp 0010", i, cl_arready); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (cl_arready !== 4'b0000) begin n_fail++; $display("FAIL os_blocked: got %b exp 0000", cl_arready); end
    cl_arvalid = 4'b1011;
    #1;
    n_checks++; if (cl_arready !== 4'b1000) begin n_fail++; $display("FAIL os_skip3: got %b exp 1000", cl_arready); end
    @(posedge clk); #1;
    n_checks++; if (usr_arid[7:6] !== 2'd3) begin n_fail++; $display("FAIL os_skip3_id: got %0d exp 3", usr_arid[7:6]); end
    #1;
    n_checks++; if (cl_arready !== 4'b0001) begin n_fail++; $display("FAIL os_skip0: got %b exp 0001", cl_arready); end
    @(posedge clk); #1;
    cl_arvalid = 4'b0010;
    usr_rvalid = 1'b1; usr_rid = 8'h40; usr_rlast = 1'b1; cl_rready = 4'b0010;
    #1;
    n_checks++; if (cl_arready !== 4'b0000) begin n_fail++; $display("FAIL os_still_full: got %b exp 0000", cl_arready); end
    n_checks++; if (cl_rvalid !== 4'b0010 || usr_rready !== 1'b1) begin n_fail++; $display("FAIL os_rlast_route: got %b/%b exp 0010/1", cl_rvalid, usr_rready); end
    @(posedge clk); #1;
    usr_rvalid = 1'b0; usr_rlast = 1'b0; cl_rready = 4'b0000;
    #1;
    n_checks++; if (cl_arready !== 4'b0010) begin n_fail++; $display("FAIL os_freed: got %b exp 0010", cl_arready); end
    @(posedge clk); #1;
    n_checks++; if (usr_arvalid !== 1'b1 || usr_arid[7:6] !== 2'd1) begin n_fail++; $display("FAIL os_freed_id: got %b/%0d exp 1/1", usr_arvalid, usr_arid[7:6]); end
    cl_arvalid = 4'b0000;
  endtask

  task automatic test_r_route();
    logic [5:0] pat;
    int b;
    pat = 6'b110101;
    b = 0;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      usr_rvalid = 1'b1; usr_rid = 8'h85;
      usr_rdata = 128'hA0 + 128'(b); usr_rlast = (b == 3); usr_rresp = 2'(b);
      cl_rready = {1'b1, pat[j], 2'b11};
      #1;
      n_checks++; if (cl_rvalid !== 4'b0100) begin n_fail++; $display("FAIL r_rvalid j=%0d: got %b exp 0100", j, cl_rvalid); end
      n_checks++; if (cl_rid !== 6'h05) begin n_fail++; $display("FAIL r_rid j=%0d: got %h exp 05", j, cl_rid); end
      n_checks++; if (usr_rready !== pat[j]) begin n_fail++; $display("FAIL r_rready j=%0d: got %b exp %b", j, usr_rready, pat[j]); end
      n_checks++; if (cl_rdata !== 128'hA0 + 128'(b) || cl_rlast !== (b == 3) || cl_rresp !== 2'(b)) begin n_fail++; $display("FAIL r_payload j=%0d: got %h/%b/%b", j, cl_rdata, cl_rlast, cl_rresp); end
      n_checks++; if (err_os_uf !== 1'b0) begin n_fail++; $display("FAIL r_uf_early j=%0d: got %b exp 0", j, err_os_uf); end
      @(posedge clk); #1;
      if (pat[j]) b++;
    end
    usr_rvalid = 1'b0; usr_rlast = 1'b0; cl_rready = 4'b0000;
    #1;
    n_checks++; if (err_os_uf !== 1'b1) begin n_fail++; $display("FAIL r_uf_set: got %b exp 1", err_os_uf); end
  endtask

  task automatic test_bad_rid();
    do_reset();
    usr_rvalid = 1'b1; usr_rid = 8'hC0; usr_rlast = 1'b1; d3_cl_rready = 3'b000;
    #1;
    n_checks++; if (d3_usr_rready !== 1'b1 || d3_cl_rvalid !== 3'b000) begin n_fail++; $display("FAIL bad_drop: got %b/%b exp 1/000", d3_usr_rready, d3_cl_rvalid); end
    n_checks++; if (d3_err_bad_rid !== 1'b0) begin n_fail++; $display("FAIL bad_early: got %b exp 0", d3_err_bad_rid); end
    n_checks++; if (cl_rvalid !== 4'b1000) begin n_fail++; $display("FAIL bad_ncl4_route: got %b exp 1000", cl_rvalid); end
    @(posedge clk); #1;
    usr_rvalid = 1'b0; usr_rlast = 1'b0;
    #1;
    n_checks++; if (d3_err_bad_rid !== 1'b1 || d3_err_os_uf !== 1'b0 || err_bad_rid !== 1'b0) begin n_fail++; $display("FAIL bad_flag: got %b/%b/%b exp 1/0/0", d3_err_bad_rid, d3_err_os_uf, err_bad_rid); end
    repeat (3) @(posedge clk);
    usr_rvalid = 1'b1; usr_rid = 8'h81; d3_cl_rready = 3'b100;
    #1;
    n_checks++; if (d3_err_bad_rid !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got %b exp 1", d3_err_bad_rid); end
    n_checks++; if (d3_cl_rvalid !== 3'b100 || d3_usr_rready !== 1'b1 || d3_cl_rid !== 6'h01) begin n_fail++; $display("FAIL ncl3_route: got %b/%b/%h exp 100/1/01", d3_cl_rvalid, d3_usr_rready, d3_cl_rid); end
    @(posedge clk); #1;
    usr_rvalid = 1'b0; d3_cl_rready = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cl_arvalid = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (usr_arvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_arvalid: got %b exp 1", usr_arvalid); end
    usr_reset_n = 1'b0; cl_arvalid = 4'b1111;
    @(posedge clk); #1;
    n_checks++; if (usr_arvalid !== 1'b0 || usr_arid !== 8'h00 || usr_araddr !== 32'h0) begin n_fail++; $display("FAIL mid_clear: got %b/%h/%h exp 0/00/0", usr_arvalid, usr_arid, usr_araddr); end
    n_checks++; if (err_os_uf !== 1'b0 || d3_err_bad_rid !== 1'b0) begin n_fail++; $display("FAIL mid_err_clear: got %b/%b exp 0/0", err_os_uf, d3_err_bad_rid); end
    usr_reset_n = 1'b1;
    #1;
    n_checks++; if (cl_arready !== 4'b0001) begin n_fail++; $display("FAIL mid_first: got %b exp 0001", cl_arready); end
    @(posedge clk); #1;
    cl_arvalid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (cl_arready !== 4'b0001) begin n_fail++; $display("FAIL mid_os_cleared i=%0d: got %b exp 0001", i, cl_arready); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (cl_arready !== 4'b0000) begin n_fail++; $display("FAIL mid_os_limit: got %b exp 0000", cl_arready); end
    cl_arvalid = 4'b0000;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      cl_arid[c*6 +: 6]    = 6'(16 + c);
      cl_araddr[c*32 +: 32] = 32'((c + 1) * 32'h1000);
      cl_arlen[c*8 +: 8]   = 8'(c);
      cl_arsize[c*3 +: 3]  = 3'd4;
      cl_arburst[c*2 +: 2] = 2'b01;
    end
    d3_cl_arid = '0; d3_cl_araddr = '0; d3_cl_arlen = '0; d3_cl_arsize = '0;
    d3_cl_arburst = '0; d3_cl_arvalid = 3'b000;
    test_reset();
    test_round_robin();
    test_stall();
    test_max_os();
    test_r_route();
    test_bad_rid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
